// File: rtl/ascon_perm_engine.sv
// ascon_perm_engine: ASCON p^a / p^b permutation on the 320-bit state.
// It computes UNROLL rounds per clock, with optional data/key XOR at load and
// a key XOR after the last round.
// Optional feature macro: ASCON_PERM_ABORT_EN adds the abort_i input.
//
// state | meaning
// IDLE  | ready for a new job; state_o holds the last result
// RUN   | applying round groups until the round index reaches ROUNDS_A
module ascon_perm_engine #(
  parameter int UNROLL   = 1,
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             mode_a_i,
  input  logic             xor_data_i,
  input  logic             xor_key_begin_i,
  input  logic             xor_key_end_i,
  input  logic             enable_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic [4:0][63:0] state_i,
  input  logic [63:0]      data_i,
  input  logic [127:0]     key_i,
  output logic [4:0][63:0] state_o,
  output logic             valid_o,
  output logic             ready_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1, 2, 3 or 6");
  end

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS_A - UNROLL);
  localparam logic [3:0] START_B  = 4'(ROUNDS_A - ROUNDS_B);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [4:0][63:0] state_q, state_d, round_out;
  logic [3:0]       idx_q, idx_d;
  logic             key_end_q, key_end_d;
  logic             valid_q, valid_d;
  logic             abort_req;

`ifdef ASCON_PERM_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // One ASCON round for round index r: constant addition, S-box, linear layer.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [4:0][63:0] o;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hF - r, r};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    o[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    o[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    o[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    o[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    o[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return o;
  endfunction

  // Chain UNROLL rounds starting at the current round index.
  always_comb begin
    round_out = state_q;
    for (int k = 0; k < UNROLL; k++) begin
      round_out = ascon_round(round_out, idx_q + 4'(k));
    end
  end

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    idx_d     = idx_q;
    key_end_d = key_end_q;
    valid_d   = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i && enable_i) begin
          state_d = state_i;
          if (xor_data_i) begin
            state_d[0] = state_d[0] ^ data_i;
          end
          if (xor_key_begin_i) begin
            state_d[3] = state_d[3] ^ key_i[127:64];
            state_d[4] = state_d[4] ^ key_i[63:0];
          end
          idx_d     = mode_a_i ? 4'd0 : START_B;
          key_end_d = xor_key_end_i;
          fsm_d     = RUN;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d   = '0;
          idx_d     = 4'd0;
          key_end_d = 1'b0;
          fsm_d     = IDLE;
        end else if (enable_i) begin
          state_d = round_out;
          if (idx_q == LAST_IDX) begin
            if (key_end_q) begin
              state_d[3] = round_out[3] ^ key_i[127:64];
              state_d[4] = round_out[4] ^ key_i[63:0];
            end
            idx_d   = 4'(ROUNDS_A);
            valid_d = 1'b1;
            fsm_d   = IDLE;
          end else begin
            idx_d = idx_q + 4'(UNROLL);
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      idx_q     <= 4'd0;
      key_end_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_end_q <= key_end_d;
      valid_q   <= valid_d;
    end
  end

  assign state_o = state_q;
  assign valid_o = valid_q;
  assign ready_o = (fsm_q == IDLE);

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench for ascon_perm_engine: two instances (UNROLL=1 and UNROLL=3) share
// stimulus and are checked every cycle against a table-driven ASCON model.
module tb_ascon_perm_engine;
  typedef logic [4:0][63:0] st_t;

  logic         clock = 1'b0;
  logic         resetb = 1'b0;
  logic         start = 1'b0;
  logic         mode_a = 1'b0;
  logic         xor_data = 1'b0;
  logic         xkb = 1'b0;
  logic         xke = 1'b0;
  logic         enable = 1'b1;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort = 1'b0;
`endif
  st_t          state_in = '0;
  logic [63:0]  data = '0;
  logic [127:0] key = '0;
  st_t          so1, so3;
  logic         v1, v3, r1, r3;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  ascon_perm_engine #(.UNROLL(1)) u_dut1 (
    .clock_i(clock), .resetb_i(resetb), .start_i(start), .mode_a_i(mode_a),
    .xor_data_i(xor_data), .xor_key_begin_i(xkb), .xor_key_end_i(xke), .enable_i(enable),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .state_i(state_in), .data_i(data), .key_i(key),
    .state_o(so1), .valid_o(v1), .ready_o(r1));

  ascon_perm_engine #(.UNROLL(3)) u_dut3 (
    .clock_i(clock), .resetb_i(resetb), .start_i(start), .mode_a_i(mode_a),
    .xor_data_i(xor_data), .xor_key_begin_i(xkb), .xor_key_end_i(xke), .enable_i(enable),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .state_i(state_in), .data_i(data), .key_i(key),
    .state_o(so3), .valid_o(v3), .ready_o(r3));

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: 5-bit S-box table applied per bit column, rotation table.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic st_t m_sub(input st_t s);
    st_t o;
    logic [4:0] col;
    o = '0;
    for (int j = 0; j < 64; j++) begin
      col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      col = SBOX[col];
      for (int w = 0; w < 5; w++) o[w][j] = col[4-w];
    end
    return o;
  endfunction

  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t m_lin(input st_t s);
    st_t o;
    for (int w = 0; w < 5; w++) o[w] = s[w] ^ m_ror(s[w], ROT_A[w]) ^ m_ror(s[w], ROT_B[w]);
    return o;
  endfunction

  function automatic logic [7:0] m_rc(input int r);
    return 8'(((15 - r) << 4) + r);
  endfunction

  function automatic st_t m_round(input st_t s, input int r);
    st_t t;
    t = s;
    t[2] = t[2] ^ {56'd0, m_rc(r)};
    return m_lin(m_sub(t));
  endfunction

  // Transaction-level model per instance: index 0 is UNROLL=1, index 1 is UNROLL=3.
  st_t m_st [2];
  bit  m_busy [2];
  bit  m_valid [2];
  bit  m_kend [2];
  int  m_idx [2];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetb) begin
        m_st[i] = '0; m_busy[i] = 0; m_valid[i] = 0; m_kend[i] = 0; m_idx[i] = 0;
      end else begin
        m_valid[i] = 0;
        if (!m_busy[i]) begin
          if (start && enable) begin
            m_st[i] = state_in;
            if (xor_data) m_st[i][0] = m_st[i][0] ^ data;
            if (xkb) begin
              m_st[i][3] = m_st[i][3] ^ key[127:64];
              m_st[i][4] = m_st[i][4] ^ key[63:0];
            end
            m_idx[i]  = mode_a ? 0 : 6;
            m_kend[i] = xke;
            m_busy[i] = 1;
          end
        end
`ifdef ASCON_PERM_ABORT_EN
        else if (abort) begin
          m_st[i] = '0; m_busy[i] = 0; m_kend[i] = 0; m_idx[i] = 0;
        end
`endif
        else if (enable) begin
          for (int k = 0; k < (i == 0 ? 1 : 3); k++) begin
            m_st[i] = m_round(m_st[i], m_idx[i]);
            m_idx[i]++;
          end
          if (m_idx[i] == 12) begin
            if (m_kend[i]) begin
              m_st[i][3] = m_st[i][3] ^ key[127:64];
              m_st[i][4] = m_st[i][4] ^ key[63:0];
            end
            m_busy[i]  = 0;
            m_valid[i] = 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("state_u1", so1, m_st[0]);
      chk("valid_u1", v1, m_valid[0]);
      chk("ready_u1", r1, !m_busy[0]);
      chk("state_u3", so3, m_st[1]);
      chk("valid_u3", v3, m_valid[1]);
      chk("ready_u3", r3, !m_busy[1]);
    end
  end

  // Drive one job at the current negedge and wait for the UNROLL=1 result.
  task automatic run_job(input string name, input bit ma, input bit xd, input bit kb, input bit ke,
                         input st_t s, input logic [63:0] d, input logic [127:0] k,
                         input int stall_at, input int stall_len,
                         input int exp1, input int exp3, input bit rand_en);
    int n, l1, l3;
    bit in_stall;
    n = 0; l1 = 0; l3 = 0;
    mode_a = ma; xor_data = xd; xkb = kb; xke = ke;
    state_in = s; data = d; key = k;
    start = 1'b1; enable = 1'b1;
    while (l1 == 0 && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (v1 && l1 == 0) l1 = n;
      if (v3 && l3 == 0) l3 = n;
      in_stall = (n >= stall_at) && (n < stall_at + stall_len);
      start = in_stall;
      if (in_stall) state_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (rand_en) enable = ($urandom_range(0, 3) != 0);
      else enable = !in_stall;
    end
    start = 1'b0;
    enable = 1'b1;
    chk({name, "_done"}, l1 != 0, 1);
    if (exp1 > 0) chk({name, "_lat_u1"}, l1, exp1);
    if (exp3 > 0) chk({name, "_lat_u3"}, l3, exp3);
  endtask

  function automatic st_t rand_state();
    st_t r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
    return r;
  endfunction

  st_t tv, pin, pout;
  localparam logic [127:0] KEY_TP = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [63:0]  DATA_TP = 64'h3230323380000000;

  initial begin
    // Pin the model on hand-derived values.
    chk("pin_rc0", m_rc(0), 8'hF0);
    chk("pin_rc11", m_rc(11), 8'h4B);
    pin = '0; pin[2] = 64'hF0;
    pout = m_sub(pin);
    chk("pin_sub_x0", pout[0], 64'h00000000000000F0);
    chk("pin_sub_x1", pout[1], 64'h00000000000000F0);
    chk("pin_sub_x2", pout[2], 64'hFFFFFFFFFFFFFF0F);
    chk("pin_sub_x3", pout[3], 64'h00000000000000F0);
    chk("pin_sub_x4", pout[4], 64'h0);
    pin = '0; pin[0] = 64'h1; pin[2] = 64'h1;
    pout = m_lin(pin);
    chk("pin_lin_x0", pout[0], 64'h0000201000000001);
    chk("pin_lin_x2", pout[2], 64'h8400000000000001);

    tv[0] = 64'h1b1354db77e0dbb4;
    tv[1] = 64'h6f140401cfa0873c;
    tv[2] = 64'hd7e8abaf45f2885a;
    tv[3] = 64'hc0c5777fa661625e;
    tv[4] = 64'hfc4374d28210928c;

    // Reset held for two edges, then idle.
    resetb = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_on = 1'b1;
    resetb = 1'b1;
    chk("rst_state_u1", so1, '0);
    chk("rst_valid_u1", v1, 0);
    chk("rst_ready_u1", r1, 1);
    chk("rst_ready_u3", r3, 1);
    repeat (5) @(negedge clock);
    chk("idle_state_u1", so1, '0);
    chk("idle_ready_u3", r3, 1);

    // Directed jobs; consecutive calls start in the previous valid cycle.
    run_job("pb",     0, 1, 0, 0, tv, DATA_TP, '0, 0, 0, 7, 3, 0);
    run_job("pa_key", 1, 0, 0, 1, tv, DATA_TP, KEY_TP, 0, 0, 13, 5, 0);
    run_job("b2b_pb", 0, 1, 0, 0, tv, DATA_TP, KEY_TP, 0, 0, 7, 3, 0);
    run_job("stall",  0, 1, 0, 0, tv, DATA_TP, KEY_TP, 1, 3, 10, 6, 0);
    run_job("pa_all", 1, 1, 1, 1, rand_state(), 64'hDEADBEEF01234567, KEY_TP, 0, 0, 13, 5, 0);

    // Reset during round 4 of a p^a job.
    @(negedge clock);
    mode_a = 1'b1; xor_data = 1'b0; xkb = 1'b0; xke = 1'b0; state_in = rand_state();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    chk("rstmid_ready_u1", r1, 1);
    chk("rstmid_valid_u1", v1, 0);
    chk("rstmid_state_u1", so1, '0);
    chk("rstmid_ready_u3", r3, 1);
    repeat (3) begin
      @(negedge clock);
      chk("rstmid_novalid_u1", v1, 0);
    end

`ifdef ASCON_PERM_ABORT_EN
    // Abort at round 3.
    mode_a = 1'b1; state_in = rand_state();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_state_u1", so1, '0);
    chk("abort_ready_u1", r1, 1);
    chk("abort_valid_u1", v1, 0);
    chk("abort_state_u3", so3, '0);
    chk("abort_ready_u3", r3, 1);
    repeat (3) begin
      @(negedge clock);
      chk("abort_novalid_u1", v1, 0);
    end
`endif

    // Randomized jobs with random flags and random enable gaps.
    for (int j = 0; j < 25; j++) begin
      run_job("rnd", 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
              rand_state(), {$urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 0, 0, 1);
    end

    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
